block_word_serializer: RTL and testbench
========================================

Name: block_word_serializer

Overview:
- Parallel-to-serial output stage that pairs with the flexbyte serial-to-parallel shift register on the data path.
- Accepts one full block (default 16 bytes, one AES state) over a valid/ready handshake.
- Emits the block as a sequence of narrower words (default 4 bytes) over a second valid/ready handshake.
- Drives the 32-bit output bus from the 128-bit cipher core result; supports back-to-back blocks with no bubble.

Parameters:
- MSB, 1: 1 = most-significant word of the block goes out first; 0 = least-significant word goes out first.
- NUM_BYTES_IN, 16: block width in bytes on the input side.
- NUM_BYTES_OUT, 4: word width in bytes on the output side.
- Derived: NUM_WORDS = NUM_BYTES_IN / NUM_BYTES_OUT; CNT_W = $clog2(NUM_WORDS).
- Elaboration checks:
  - $fatal if NUM_BYTES_IN <= NUM_BYTES_OUT.
  - $fatal if NUM_BYTES_IN % NUM_BYTES_OUT != 0. A partial word is not supported.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  reset, asynchronous, active-low.
- block_valid  in  1  block_in holds a valid block.
- block_in  in  NUM_BYTES_IN*8  block to serialize.
- block_ready  out  1  block is accepted this cycle when block_valid is also high.
- word_ready  in  1  downstream accepts word_out this cycle.
- word_valid  out  1  word_out holds a valid word.
- word_out  out  NUM_BYTES_OUT*8  current word.
- word_last  out  1  current word is the final word of its block.
- busy  out  1  a block is in progress (state SEND).

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous and active-low.
- Storage:
  - buf_q, NUM_BYTES_IN*8 bits.
  - cnt_q, CNT_W bits.
  - state_q, encoded IDLE/SEND.
- Reset values:
  - state = IDLE, buf_q = 0, cnt_q = 0.
  - Outputs during reset: word_valid = 0, word_last = 0, busy = 0, word_out = 0, block_ready = 1.
- Definitions:
  - word_valid = (state == SEND).
  - busy = word_valid.
  - word_last = word_valid && (cnt_q == NUM_WORDS-1).
- word_out selection:
  - MSB=1: word_out = buf_q[NUM_BYTES_IN*8-1 -: NUM_BYTES_OUT*8].
  - MSB=0: word_out = buf_q[NUM_BYTES_OUT*8-1:0].
- block_ready = (state == IDLE) || (word_valid && word_last && word_ready). This is a combinational path from word_ready and is intentional, for full throughput.
- load = block_valid && block_ready. On load:
  - buf_q <= block_in, cnt_q <= 0, state <= SEND.
  - The first word is valid on the cycle after load, so load-to-first-word latency is 1 cycle.
- fire = word_valid && word_ready. On fire without load:
  - MSB=1: buf_q shifts left by NUM_BYTES_OUT*8 bits. MSB=0: buf_q shifts right by the same amount. Vacated bits fill with 0.
  - cnt_q increments.
  - If word_last, state <= IDLE and cnt_q <= 0.
- Simultaneous events:
  - fire of the last word together with load: load wins. The new block is captured, state stays SEND and cnt_q = 0, so there is no idle cycle between blocks.
  - block_valid while in SEND and not on the last-word fire: ignored. block_ready = 0, and the upstream block must be held.
- Backpressure: while word_valid && !word_ready, buf_q, cnt_q, word_out and word_last hold unchanged. The stall length is unbounded.
- block_in is sampled only on load. Changes at other times have no effect.
- Throughput: one word per cycle while word_ready = 1. Sustained NUM_WORDS cycles per block.
- Reset mid-block: the remaining words are discarded. Output returns to the reset values immediately (asynchronous), and the next loaded block starts from word 0.
- word_valid never deasserts before fire (no retraction).

Test Plan:
1. Reset: assert n_rst = 0 with random inputs -> word_valid = 0, busy = 0, word_out = 0, block_ready = 1; hold 3 cycles, values stable.
2. MSB=1, word_ready = 1, load 128'h00112233_445566778_899AABB_CCDDEEFF with the first word group read as 00112233 and the remaining bytes 44556677, 8899AABB, CCDDEEFF -> words 00112233, 44556677, 8899AABB, CCDDEEFF on the 4 cycles after load; word_last only on CCDDEEFF; block_ready = 0 on the first 3 of those cycles.
3. Backpressure: same block, word_ready = 0 for 3 cycles while 44556677 is presented -> word_out stays 44556677, word_valid = 1, word_last = 0; sequence resumes with 8899AABB.
4. Back-to-back: second block 128'hFFEEDDCC_BBAA9988_77665544_33221100 held valid during the first block -> accepted exactly on the CCDDEEFF fire cycle; next cycle word_out = FFEEDDCC; 8 words in 8 consecutive cycles.
5. MSB=0 instance, block from test 2 -> order CCDDEEFF, 8899AABB, 44556677, 00112233, with word_last on 00112233.
6. Reset mid-block: pulse n_rst low after 00112233 is accepted -> word_valid drops asynchronously; after release, load the block from test 4 -> output starts at FFEEDDCC with a 4-word sequence.

Source files
------------

// File: rtl/block_word_serializer_if.sv
// Handshake bundle for block_word_serializer: block-in (valid/ready) and word-out (valid/ready/last).
// The master modport is the side that feeds blocks and drains words; the slave modport is the serializer.
interface block_word_serializer_if #(
  parameter int NUM_BYTES_IN  = 16,
  parameter int NUM_BYTES_OUT = 4
);
  logic                       block_valid;
  logic [NUM_BYTES_IN*8-1:0]  block_in;
  logic                       block_ready;
  logic                       word_ready;
  logic                       word_valid;
  logic [NUM_BYTES_OUT*8-1:0] word_out;
  logic                       word_last;
  logic                       busy;

  modport master (
    output block_valid, block_in, word_ready,
    input  block_ready, word_valid, word_out, word_last, busy
  );

  modport slave (
    input  block_valid, block_in, word_ready,
    output block_ready, word_valid, word_out, word_last, busy
  );
endinterface

// File: rtl/block_word_serializer.sv
// Parallel-to-serial stage: captures one NUM_BYTES_IN block and emits it as NUM_BYTES_OUT words,
// MSB- or LSB-word first, with back-to-back block acceptance on the last-word handshake.
module block_word_serializer #(
  parameter int MSB           = 1,
  parameter int NUM_BYTES_IN  = 16,
  parameter int NUM_BYTES_OUT = 4
) (
  input logic                    clk,
  input logic                    n_rst,
  block_word_serializer_if.slave bus
);
  localparam int NUM_WORDS = NUM_BYTES_IN / NUM_BYTES_OUT;
  localparam int CNT_W     = $clog2(NUM_WORDS);
  localparam int IN_W      = NUM_BYTES_IN * 8;
  localparam int OUT_W     = NUM_BYTES_OUT * 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_WORDS - 1);

  if (NUM_BYTES_IN <= NUM_BYTES_OUT) begin : g_bad_ratio
    $fatal(1, "block_word_serializer: NUM_BYTES_IN must exceed NUM_BYTES_OUT");
  end
  if ((NUM_BYTES_IN % NUM_BYTES_OUT) != 0) begin : g_bad_multiple
    $fatal(1, "block_word_serializer: NUM_BYTES_IN must be a multiple of NUM_BYTES_OUT");
  end

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t            state_q;
  logic [IN_W-1:0]   buf_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              word_valid_s;
  logic              word_last_s;
  logic              block_ready_s;
  logic              load_s;
  logic              fire_s;
  logic [OUT_W-1:0]  word_s;
  logic [IN_W-1:0]   buf_shift_s;

  // Handshake decode; block_ready depends on word_ready so a new block lands on the last-word fire.
  always_comb begin
    word_valid_s  = (state_q == SEND);
    word_last_s   = word_valid_s && (cnt_q == CNT_LAST);
    block_ready_s = (state_q == IDLE) || (word_valid_s && word_last_s && bus.word_ready);
    load_s        = bus.block_valid && block_ready_s;
    fire_s        = word_valid_s && bus.word_ready;
  end

  if (MSB != 0) begin : g_msb_first
    assign word_s      = buf_q[IN_W-1 -: OUT_W];
    assign buf_shift_s = {buf_q[IN_W-OUT_W-1:0], {OUT_W{1'b0}}};
  end else begin : g_lsb_first
    assign word_s      = buf_q[OUT_W-1:0];
    assign buf_shift_s = {{OUT_W{1'b0}}, buf_q[IN_W-1:OUT_W]};
  end

  // Control FSM and data path; load takes priority over the last-word fire so blocks chain without a bubble.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      buf_q   <= {IN_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
    end else if (load_s) begin
      state_q <= SEND;
      buf_q   <= bus.block_in;
      cnt_q   <= {CNT_W{1'b0}};
    end else if (fire_s) begin
      buf_q <= buf_shift_s;
      case (word_last_s)
        1'b1: begin
          state_q <= IDLE;
          cnt_q   <= {CNT_W{1'b0}};
        end
        default: begin
          state_q <= state_q;
          cnt_q   <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      endcase
    end else begin
      state_q <= state_q;
      buf_q   <= buf_q;
      cnt_q   <= cnt_q;
    end
  end

  assign bus.word_valid  = word_valid_s;
  assign bus.busy        = word_valid_s;
  assign bus.word_last   = word_last_s;
  assign bus.word_out    = word_s;
  assign bus.block_ready = block_ready_s;
endmodule

// File: tb/tb_block_word_serializer.sv
// Scoreboard bench for block_word_serializer: one MSB-first and one LSB-first instance,
// expected words queued on every observed block handshake and popped on every word handshake.
module tb_block_word_serializer;
  localparam logic [127:0] B1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] B2 = 128'hFFEEDDCC_BBAA9988_77665544_33221100;

  typedef struct {
    logic [31:0] word;
    logic        last;
  } exp_t;

  logic clk;
  logic n_rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_pop_m  = 0;
  int   n_pop_l  = 0;
  exp_t exp_m[$];
  exp_t exp_l[$];

  block_word_serializer_if #(.NUM_BYTES_IN(16), .NUM_BYTES_OUT(4)) bm ();
  block_word_serializer_if #(.NUM_BYTES_IN(16), .NUM_BYTES_OUT(4)) bl ();

  block_word_serializer #(.MSB(1), .NUM_BYTES_IN(16), .NUM_BYTES_OUT(4)) u_msb (
    .clk(clk), .n_rst(n_rst), .bus(bm)
  );
  block_word_serializer #(.MSB(0), .NUM_BYTES_IN(16), .NUM_BYTES_OUT(4)) u_lsb (
    .clk(clk), .n_rst(n_rst), .bus(bl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] nth_word(input logic [127:0] b, input int i, input bit msb_first);
    return msb_first ? b[127-32*i -: 32] : b[32*i +: 32];
  endfunction

  // Scoreboard: compare words on fire, then queue the words of any block accepted this cycle.
  always @(negedge clk) begin
    exp_t e;
    if (n_rst) begin
      if (bm.word_valid && bm.word_ready) begin
        if (exp_m.size() == 0) check("m_sb_underflow", 128'(exp_m.size()), 128'd1);
        else begin
          e = exp_m.pop_front();
          check("m_word", 128'(bm.word_out), 128'(e.word));
          check("m_last", 128'(bm.word_last), 128'(e.last));
          n_pop_m++;
        end
      end
      if (bl.word_valid && bl.word_ready) begin
        if (exp_l.size() == 0) check("l_sb_underflow", 128'(exp_l.size()), 128'd1);
        else begin
          e = exp_l.pop_front();
          check("l_word", 128'(bl.word_out), 128'(e.word));
          check("l_last", 128'(bl.word_last), 128'(e.last));
          n_pop_l++;
        end
      end
      if (bm.block_valid && bm.block_ready)
        for (int i = 0; i < 4; i++) exp_m.push_back('{nth_word(bm.block_in, i, 1'b1), (i == 3)});
      if (bl.block_valid && bl.block_ready)
        for (int i = 0; i < 4; i++) exp_l.push_back('{nth_word(bl.block_in, i, 1'b0), (i == 3)});
    end
  end

  task automatic idle_inputs();
    bm.block_valid = 1'b0; bm.block_in = 128'd0; bm.word_ready = 1'b0;
    bl.block_valid = 1'b0; bl.block_in = 128'd0; bl.word_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 128'(bm.word_valid), 128'd0);
    check({tag, "_busy"},  128'(bm.busy), 128'd0);
    check({tag, "_last"},  128'(bm.word_last), 128'd0);
    check({tag, "_word"},  128'(bm.word_out), 128'd0);
    check({tag, "_ready"}, 128'(bm.block_ready), 128'd1);
    check({tag, "_l_valid"}, 128'(bl.word_valid), 128'd0);
  endtask

  initial begin
    int pops0;
    idle_inputs();
    n_rst = 1'b1;
    #1 n_rst = 1'b0;

    // Reset with random inputs, held three cycles
    for (int c = 0; c < 3; c++) begin
      bm.block_valid = 1'($urandom); bm.word_ready = 1'($urandom);
      bm.block_in = {$urandom, $urandom, $urandom, $urandom};
      bl.block_valid = 1'($urandom); bl.word_ready = 1'($urandom);
      bl.block_in = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      check_reset_outputs("rst");
    end
    @(posedge clk); #1;
    idle_inputs();
    n_rst = 1'b1;

    // MSB-first block, word_ready held high
    bm.block_in = B1; bm.block_valid = 1'b1; bm.word_ready = 1'b1;
    @(negedge clk);
    check("t2_idle_ready", 128'(bm.block_ready), 128'd1);
    @(posedge clk); #1;
    bm.block_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t2_valid", 128'(bm.word_valid), 128'd1);
      check("t2_busy", 128'(bm.busy), 128'd1);
      check("t2_ready", 128'(bm.block_ready), 128'(k == 3));
      if (k == 0) check("t2_first", 128'(bm.word_out), 128'h00112233);
    end
    @(negedge clk);
    check("t2_done", 128'(bm.word_valid), 128'd0);

    // Backpressure on the second word
    @(posedge clk); #1;
    bm.block_in = B1; bm.block_valid = 1'b1; bm.word_ready = 1'b1;
    @(posedge clk); #1;
    bm.block_valid = 1'b0;
    @(posedge clk); #1;
    bm.word_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t3_hold_word", 128'(bm.word_out), 128'h44556677);
      check("t3_hold_valid", 128'(bm.word_valid), 128'd1);
      check("t3_hold_last", 128'(bm.word_last), 128'd0);
    end
    @(posedge clk); #1;
    bm.word_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t3_resume_valid", 128'(bm.word_valid), 128'd1);
    end
    @(negedge clk);
    check("t3_done", 128'(bm.word_valid), 128'd0);

    // Back-to-back blocks: second block held valid through the first
    @(posedge clk); #1;
    pops0 = n_pop_m;
    bm.block_in = B1; bm.block_valid = 1'b1; bm.word_ready = 1'b1;
    @(posedge clk); #1;
    bm.block_in = B2;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t4_a_valid", 128'(bm.word_valid), 128'd1);
      check("t4_a_ready", 128'(bm.block_ready), 128'(k == 3));
    end
    @(posedge clk); #1;
    bm.block_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t4_b_valid", 128'(bm.word_valid), 128'd1);
      if (k == 0) check("t4_b_first", 128'(bm.word_out), 128'hFFEEDDCC);
    end
    @(negedge clk);
    check("t4_done", 128'(bm.word_valid), 128'd0);
    check("t4_word_count", 128'(n_pop_m - pops0), 128'd8);

    // LSB-first instance, same block
    @(posedge clk); #1;
    bl.block_in = B1; bl.block_valid = 1'b1; bl.word_ready = 1'b1;
    @(posedge clk); #1;
    bl.block_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t5_valid", 128'(bl.word_valid), 128'd1);
      check("t5_last", 128'(bl.word_last), 128'(k == 3));
      if (k == 0) check("t5_first", 128'(bl.word_out), 128'hCCDDEEFF);
    end
    @(negedge clk);
    check("t5_done", 128'(bl.word_valid), 128'd0);

    // Reset mid-block after the first word is accepted
    @(posedge clk); #1;
    bm.block_in = B1; bm.block_valid = 1'b1; bm.word_ready = 1'b1;
    @(posedge clk); #1;
    bm.block_valid = 1'b0;
    @(posedge clk); #2;
    n_rst = 1'b0;
    exp_m.delete();
    exp_l.delete();
    #1;
    check_reset_outputs("t6_rst");
    @(posedge clk); #1;
    n_rst = 1'b1;
    bm.block_in = B2; bm.block_valid = 1'b1;
    @(posedge clk); #1;
    bm.block_valid = 1'b0;
    pops0 = n_pop_m;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t6_valid", 128'(bm.word_valid), 128'd1);
      if (k == 0) check("t6_first", 128'(bm.word_out), 128'hFFEEDDCC);
    end
    @(negedge clk);
    check("t6_done", 128'(bm.word_valid), 128'd0);
    check("t6_word_count", 128'(n_pop_m - pops0), 128'd4);

    check("sb_m_empty", 128'(exp_m.size()), 128'd0);
    check("sb_l_empty", 128'(exp_l.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
